// File: rtl/rotate_pattern_gen.sv
// rotate_pattern_gen: square that rotates around a multiplexed 7-segment display.
// Define ROTATE_BOUNCE_EN to add the bounce mode selected by the mode input.
module rotate_pattern_gen #(
  parameter int N_DIGITS = 4,
  parameter int STEP_DIV = 25000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cw,
  input  logic                mode,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          sseg,
  output logic                wrap
);
  localparam int TW = $clog2(STEP_DIV);
  localparam int KW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(N_DIGITS);
  localparam int PW = SW + 1;
  localparam logic [TW-1:0] STEP_MAX = TW'(STEP_DIV - 1);
  localparam logic [KW-1:0] SCAN_MAX = KW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(N_DIGITS - 1);
  localparam logic [PW-1:0] P_MAX = PW'(2 * N_DIGITS - 1);
  localparam logic [PW-1:0] P_HALF = PW'(N_DIGITS);
  logic [TW-1:0] step_q, step_d;
  logic [KW-1:0] scan_q, scan_d;
  logic [SW-1:0] s_q, s_d;
  logic [PW-1:0] p_q, p_d, p_inc, p_dec, p_nx, act;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0] sseg_q, sseg_d;
  logic wrap_q, wrap_d, tick, bounce, up;
`ifdef ROTATE_BOUNCE_EN
  logic mode_q, dir_q, dir_d, entry, bdir;
  // Ends force the direction so a stale dir bit can never step past 0 or P_MAX.
  always_comb begin
    entry = mode && !mode_q;
    bdir = p_q == P_MAX ? 1'b0 : p_q == '0 ? 1'b1 : entry ? cw : dir_q;
    bounce = mode;
    up = mode ? bdir : cw;
    dir_d = tick && mode ? (p_nx == P_MAX ? 1'b0 : p_nx == '0 ? 1'b1 : bdir) : entry ? cw : dir_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
      dir_q  <= 1'b1;
    end else begin
      mode_q <= mode;
      dir_q  <= dir_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign bounce = 1'b0;
  assign up = cw;
`endif
  always_comb begin
    tick = en && step_q == STEP_MAX;
    step_d = tick ? '0 : step_q + TW'(en);
    scan_d = scan_q == SCAN_MAX ? '0 : scan_q + KW'(1);
    s_d = scan_q != SCAN_MAX ? s_q : s_q == S_MAX ? '0 : s_q + SW'(1);
    p_inc = p_q == P_MAX ? '0 : p_q + PW'(1);
    p_dec = p_q == '0 ? P_MAX : p_q - PW'(1);
    p_nx = up ? p_inc : p_dec;
    p_d = tick ? p_nx : p_q;
    wrap_d = tick && !bounce && (cw ? p_q == P_MAX : p_q == '0);
    act = p_q < P_HALF ? p_q : P_MAX - p_q;
    an_d = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << s_q);
    sseg_d = {1'b0, s_q} != act ? 7'b1111111 : p_q < P_HALF ? 7'b0011100 : 7'b0100011;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
      scan_q <= '0;
      s_q    <= '0;
      p_q    <= '0;
      an_q   <= '1;
      sseg_q <= 7'b1111111;
      wrap_q <= 1'b0;
    end else begin
      step_q <= step_d;
      scan_q <= scan_d;
      s_q    <= s_d;
      p_q    <= p_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      wrap_q <= wrap_d;
    end
  end
  assign an = an_q;
  assign sseg = sseg_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_rotate_pattern_gen.sv
// tb_rotate_pattern_gen: scoreboard bench for rotate_pattern_gen (N=4, STEP_DIV=4, SCAN_DIV=2).
module tb_rotate_pattern_gen;
  localparam int N = 4;
  logic clk = 0, rst = 1, en = 0, cw = 1, mode = 0;
  logic [N-1:0] an;
  logic [6:0] sseg;
  logic wrap;
  int checks = 0, failures = 0, wraps = 0;
  typedef struct packed {logic [3:0] an; logic [6:0] sseg; logic wrap;} exp_t;
  exp_t q[$];
  int m_step, m_p, m_s, m_scan;
  bit m_dir, m_mq;

  rotate_pattern_gen #(.N_DIGITS(4), .STEP_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cw(cw), .mode(mode),
    .an(an), .sseg(sseg), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_step = 0; m_p = 0; m_s = 0; m_scan = 0; m_dir = 1; m_mq = 0;
    q.delete();
  endtask

  // Predict the registered outputs for the coming edge, queue them, then advance.
  task automatic drive_cycle();
    exp_t e;
    int act;
    bit tick, bnc;
    act = m_p < N ? m_p : 2*N-1-m_p;
    e.an = ~(4'b0001 << m_s);
    e.sseg = (m_s == act) ? (m_p < N ? 7'b0011100 : 7'b0100011) : 7'b1111111;
    e.wrap = 0;
`ifdef ROTATE_BOUNCE_EN
    bnc = mode;
`else
    bnc = 0;
`endif
    tick = en && m_step == 3;
    if (bnc && !m_mq) m_dir = cw;
    if (tick) begin
      if (bnc) begin
        if (m_p == 2*N-1) m_dir = 0;
        if (m_p == 0) m_dir = 1;
        m_p = m_p + (m_dir ? 1 : -1);
      end else begin
        e.wrap = (cw && m_p == 2*N-1) || (!cw && m_p == 0);
        m_p = (m_p + (cw ? 1 : 2*N-1)) % (2*N);
      end
    end
    m_step = tick ? 0 : m_step + (en ? 1 : 0);
    m_mq = bnc;
    if (m_scan == 1) begin m_scan = 0; m_s = (m_s + 1) % N; end
    else m_scan++;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 rst = 0;
    #10;
    checks++;
    if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b want=1111", an); end
    checks++;
    if (sseg !== 7'b1111111) begin failures++; $display("FAIL reset_sseg got=%b want=1111111", sseg); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    @(posedge clk); #1 rst = 1;
    model_reset();
    drive_cycle();
    e = q.pop_front();
    checks++;
    if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL reset_first got=%b_%b_%b want=%b", an, sseg, wrap, e); end
    checks++;
    if (an !== 4'b1110 || sseg !== 7'b0011100) begin failures++; $display("FAIL reset_release got=%b/%b want=1110/0011100", an, sseg); end
  endtask

  task automatic test_loop();
    exp_t e;
    en = 1; cw = 1; wraps = 0;
    for (int i = 0; i < 34; i++) begin
      drive_cycle();
      e = q.pop_front();
      if (wrap) wraps++;
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL loop c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    checks++;
    if (wraps !== 1) begin failures++; $display("FAIL loop_wraps got=%0d want=1", wraps); end
  endtask

  task automatic test_ccw();
    exp_t e;
    cw = 0; wraps = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      e = q.pop_front();
      if (wrap) wraps++;
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL ccw c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    checks++;
    if (wraps !== 1) begin failures++; $display("FAIL ccw_wraps got=%0d want=1", wraps); end
    cw = 1;
  endtask

  task automatic test_hold();
    exp_t e;
    int hits = 0;
    for (int i = 0; i < 100 && m_p != 3; i++) begin
      drive_cycle();
      e = q.pop_front();
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL hold_seek c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    en = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      e = q.pop_front();
      if (an === 4'b0111 && sseg === 7'b0011100) hits++;
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL hold c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    checks++;
    if (hits < 4 || hits > 6) begin failures++; $display("FAIL hold_digit3 got=%0d want=4..6", hits); end
    en = 1;
  endtask

  task automatic test_digit();
    exp_t e;
    for (int i = 0; i < 100 && m_p != 5; i++) begin
      drive_cycle();
      e = q.pop_front();
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL digit_seek c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    en = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      e = q.pop_front();
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL digit c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
      if (an === 4'b1011) begin
        checks++;
        if (sseg !== 7'b0100011) begin failures++; $display("FAIL digit_s2 got=%b want=0100011", sseg); end
      end
      if (an === 4'b1101) begin
        checks++;
        if (sseg !== 7'b1111111) begin failures++; $display("FAIL digit_s1 got=%b want=1111111", sseg); end
      end
    end
    en = 1;
  endtask

`ifdef ROTATE_BOUNCE_EN
  task automatic test_bounce();
    exp_t e;
    rst = 0; en = 0; mode = 1; cw = 1;
    @(posedge clk); #1 rst = 1;
    model_reset();
    en = 1; wraps = 0;
    for (int i = 0; i < 68; i++) begin
      drive_cycle();
      e = q.pop_front();
      if (wrap) wraps++;
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL bounce c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    checks++;
    if (wraps !== 0) begin failures++; $display("FAIL bounce_wraps got=%0d want=0", wraps); end
    mode = 0;
  endtask
`endif

  task automatic test_midreset();
    exp_t e;
    en = 1; cw = 1;
    for (int i = 0; i < 100 && !(m_p == 6 && m_step == 2); i++) begin
      drive_cycle();
      e = q.pop_front();
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL mid_seek c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
    #2 rst = 0;
    #1;
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111 || wrap !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%b want=1111/1111111/0", an, sseg, wrap);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111) begin failures++; $display("FAIL mid_hold got=%b/%b want=1111/1111111", an, sseg); end
    rst = 1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive_cycle();
      e = q.pop_front();
      if (i == 0) begin
        checks++;
        if (an !== 4'b1110 || sseg !== 7'b0011100) begin failures++; $display("FAIL mid_first got=%b/%b want=1110/0011100", an, sseg); end
      end
      checks++;
      if ({an, sseg, wrap} !== e) begin failures++; $display("FAIL mid_after c%0d got=%b_%b_%b want=%b", i, an, sseg, wrap, e); end
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_ccw();
    test_hold();
    test_digit();
`ifdef ROTATE_BOUNCE_EN
    test_bounce();
`endif
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rotate_pattern_gen.md
ROTATE_PATTERN_GEN -- requirements
Module: rotate_pattern_gen

Interface
REQ-001 The module SHALL have parameter N_DIGITS, default 4, number of seven-segment digits driven (2..8).
REQ-002 The module SHALL have parameter STEP_DIV, default 25000000, clock cycles per pattern step (>=2).
REQ-003 The module SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit-scan advance (>=1).
REQ-004 The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port en  input  1  high = pattern advances; low = step counter and position frozen.
REQ-007 The module SHALL have port cw  input  1  1 = clockwise (position increments), 0 = counter-clockwise.
REQ-008 The module SHALL have port mode  input  1  0 = loop, 1 = bounce (only with ROTATE_BOUNCE_EN).
REQ-009 The module SHALL have port an  output  N_DIGITS  digit enables, active-low, registered.
REQ-010 The module SHALL have port sseg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 The module SHALL have port wrap  output  1  one-cycle pulse when position passes 2*N_DIGITS-1 -> 0 or 0 -> 2*N_DIGITS-1.

Function
REQ-012 Step counter SHALL count 0..STEP_DIV-1 while en=1, hold while en=0, and generate a one-cycle step tick on the cycle it holds STEP_DIV-1 and en=1.
REQ-013 Position p SHALL range 0..2*N_DIGITS-1; p<N_DIGITS = upper square on digit p; p>=N_DIGITS = lower square on digit 2*N_DIGITS-1-p.
REQ-014 Loop mode: on step tick, p SHALL increment modulo 2*N_DIGITS if cw=1, else decrement modulo 2*N_DIGITS.
REQ-015 Bounce mode: internal direction bit SHALL be loaded from cw on entry to bounce mode; on tick p moves one step in that direction and the direction inverts on reaching p=0 or p=2*N_DIGITS-1 (no wrap; wrap never pulses).
REQ-016 cw changes SHALL take effect on the next step tick; a change coincident with a tick SHALL be applied on that tick.
REQ-017 Scan counter SHALL advance digit index s every SCAN_DIV cycles, s wrapping N_DIGITS-1 -> 0, independent of en.
REQ-018 an SHALL be registered as all ones except bit s low.
REQ-019 sseg SHALL be registered as 7'b0011100 (upper square, segments a,b,f,g) or 7'b0100011 (lower square, segments c,d,e,g) when s equals the active digit, else 7'b1111111.
REQ-020 an/sseg SHALL reflect s and p with exactly one cycle latency.
REQ-021 wrap SHALL be registered, asserted in the cycle after the wrapping tick.

Reset
REQ-022 While rst=0: p=0, s=0, step/scan counters=0, direction=clockwise, an=all ones, sseg=7'b1111111, wrap=0.
REQ-023 Assertion mid-operation SHALL clear state immediately; after deassertion, first registered update SHALL show s=0, p=0 (an bit0 low, sseg=7'b0011100).

Configuration
REQ-024 With ROTATE_BOUNCE_EN defined, mode SHALL select loop/bounce per REQ-014/015.
REQ-025 Without ROTATE_BOUNCE_EN, mode SHALL be ignored, no direction register synthesised, and loop behaviour SHALL always apply.

Verification (N_DIGITS=4, STEP_DIV=4, SCAN_DIV=2)
REQ-026 Reset then en=1, cw=1 -> p steps every 4 cycles 0,1,...,7,0; wrap pulses once at 7->0.
REQ-027 cw=0 from p=0 -> next tick p=7 (lower square, digit 0); wrap pulses.
REQ-028 en=0 for 20 cycles at p=3 -> p stays 3, scan continues, an rotates 1110,1101,1011,0111 every 2 cycles.
REQ-029 s=2 with p=5 -> an=4'b1011, sseg=7'b0100011; s=1 -> sseg=7'b1111111.
REQ-030 ROTATE_BOUNCE_EN, mode=1, cw=1 from p=0 -> p 1..7 then 6,5,...,0,1; wrap never asserted.
REQ-031 rst pulsed low mid-step at p=6 -> an=1111, sseg=1111111 immediately; after release p=0, counters restart from 0.
